axi_write_arbiter_rr: RTL and testbench
=======================================

Name: axi_write_arbiter_rr

Overview:
- Parametrised N-master write-address arbiter for the AXI interconnect; successor to the fixed two-slave AW arbiter.
- Selects one master's AW request, holds the grant through the AW handshake, the W burst (WLAST) and the B response, then re-arbitrates.
- Supports fixed-priority or round-robin mode.
- Drives the one-hot/encoded select used by the AW/W/B muxes and the channel-request line to the downstream address channel.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (>=2).
- ID_W, $clog2(NUM_MASTERS), width of the encoded grant index.
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (index 0 highest).

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- M_AWVALID  in  NUM_MASTERS  per-master AWVALID requests.
- Channel_Granted  in  1  downstream address channel available; arbitration is allowed only when high.
- AW_HS  in  1  muxed AWVALID&AWREADY handshake at the arbiter output.
- W_LAST_HS  in  1  muxed WVALID&WREADY&WLAST handshake.
- B_HS  in  1  muxed BVALID&BREADY handshake.
- Channel_Request  out  1  high while a grant is active (ADDR/DATA/RESP).
- Grant_OneHot  out  NUM_MASTERS  one-hot grant, registered.
- Selected_Slave  out  ID_W  encoded grant index, registered.
- Busy  out  1  state != IDLE.

Behaviour:
- Reset (ARESET=1, asynchronous): state=IDLE, Grant_OneHot=0, Selected_Slave=0, Channel_Request=0, Busy=0, rr_ptr=NUM_MASTERS-1, wlast_seen=0.
- States: IDLE, ADDR, DATA, RESP.
- IDLE: if Channel_Granted && |M_AWVALID, register the winner → ADDR. Grant outputs are valid the cycle after the request is seen (1-cycle latency). Otherwise stay IDLE and keep all outputs 0.
- Fixed mode: lowest set index wins.
- RR mode: search starts at rr_ptr+1 modulo NUM_MASTERS; first set bit wins. The search wraps from NUM_MASTERS-1 to 0.
- ADDR: W_LAST_HS sets wlast_seen, since AXI allows W before AW.
  - On AW_HS: → RESP if wlast_seen or W_LAST_HS in the same cycle; else → DATA.
- DATA: on W_LAST_HS → RESP.
- RESP: on B_HS → IDLE. Clear the grant outputs and wlast_seen, and set rr_ptr = Selected_Slave.
- Grant is locked once issued. Requester AWVALID dropping and Channel_Granted dropping do not revoke it.
- B_HS in any state other than RESP is ignored. AW_HS in DATA/RESP is ignored. W_LAST_HS in IDLE is ignored.
- Back-to-back transactions: at least one IDLE cycle between B_HS and the next grant.
- rr_ptr is updated only on completion. Fixed mode ignores rr_ptr.
- Invariants:
  - Grant_OneHot is zero or one-hot.
  - Selected_Slave always equals the encode of Grant_OneHot while Busy.
  - Channel_Request == Busy.
- Mid-transaction ARESET returns all state to reset values immediately. There is no completion or cleanup.

Decomposition:
- Shared package axi_ic_pkg:
  - state enum (IDLE/ADDR/DATA/RESP)
  - RR_MODE encodings
  - clog2-safe ID width helper
- Sub-module rr_priority_picker (combinational): inputs req vector, pointer, mode; outputs one-hot winner, encoded index, any_req.
- The arbiter FSM and registers stay in the top.

Test Plan:
- Reset: assert ARESET mid-DATA with Grant_OneHot=4'b0100 → all outputs 0 asynchronously; after release, rr_ptr=3, so with M_AWVALID=4'b1111 the first grant is index 0.
- RR fairness: NUM_MASTERS=4, M_AWVALID=4'b1111 held, each transaction completed with AW_HS, W_LAST_HS, B_HS → grants cycle 0,1,2,3,0 with one IDLE cycle between.
- Fixed mode: RR_MODE=0, M_AWVALID=4'b1010 repeated → grant is index 1 every time; index 3 is starved.
- Lock and gating:
  - Channel_Granted=0 with requests pending → no grant.
  - Raise it, granted index 2, then drop M_AWVALID[2] and Channel_Granted → grant held until B_HS.
- W before AW: in ADDR, W_LAST_HS then AW_HS two cycles later → state goes ADDR→RESP and skips DATA. AW_HS and W_LAST_HS in the same cycle also → RESP.
- Wrap and spurious events: rr_ptr=2, M_AWVALID=4'b0011 → grant index 0. A stray B_HS during DATA is ignored; state stays DATA until W_LAST_HS.

Source files
------------

// File: rtl/axi_ic_pkg.sv
// Shared types and helpers for the AXI interconnect write-path blocks.
package axi_ic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } arb_state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Never returns 0, so a grant index port stays at least one bit wide.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational winner selection: fixed priority from index 0, or a
// round-robin search starting just after the pointer and wrapping.
module rr_priority_picker
    import axi_ic_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ID_W        = id_width(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [ID_W-1:0]        ptr,
    input  logic                   mode,
    output logic [NUM_MASTERS-1:0] winner,
    output logic [ID_W-1:0]        index,
    output logic                   any_req
);

    localparam logic [ID_W-1:0] LAST = ID_W'(NUM_MASTERS - 1);

    logic [ID_W-1:0] cand;
    logic            found;

    assign any_req = |req;

    always_comb begin
        // NOTE: every output and temporary gets a default before the search so
        // no path leaves a value unassigned, which would infer a latch.
        winner = '0;
        index  = '0;
        found  = 1'b0;
        if (mode == MODE_RR) begin
            cand = (ptr == LAST) ? '0 : ptr + 1'b1;
        end else begin
            cand = '0;
        end
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!found && req[cand]) begin
                found         = 1'b1;
                winner[cand]  = 1'b1;
                index         = cand;
            end
            cand = (cand == LAST) ? '0 : cand + 1'b1;
        end
    end

endmodule

// File: rtl/axi_write_arbiter_rr.sv
// N-master AW arbiter: grants one master and holds it through AW, the W burst
// and the B response, then re-arbitrates with at least one idle cycle between.
module axi_write_arbiter_rr
    import axi_ic_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ID_W        = id_width(NUM_MASTERS),
    parameter int RR_MODE     = 1
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic [NUM_MASTERS-1:0] M_AWVALID,
    input  logic                   Channel_Granted,
    input  logic                   AW_HS,
    input  logic                   W_LAST_HS,
    input  logic                   B_HS,
    output logic                   Channel_Request,
    output logic [NUM_MASTERS-1:0] Grant_OneHot,
    output logic [ID_W-1:0]        Selected_Slave,
    output logic                   Busy
);

    localparam logic PICK_MODE = (RR_MODE != 0) ? MODE_RR : MODE_FIXED;

    arb_state_t             state;
    logic [ID_W-1:0]        rr_ptr;
    logic                   wlast_seen;
    logic [NUM_MASTERS-1:0] pick_onehot;
    logic [ID_W-1:0]        pick_index;
    logic                   pick_any;

    rr_priority_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .ID_W        (ID_W)
    ) u_picker (
        .req     (M_AWVALID),
        .ptr     (rr_ptr),
        .mode    (PICK_MODE),
        .winner  (pick_onehot),
        .index   (pick_index),
        .any_req (pick_any)
    );

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values of its peers.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state          <= ST_IDLE;
            Grant_OneHot   <= '0;
            Selected_Slave <= '0;
            rr_ptr         <= ID_W'(NUM_MASTERS - 1);
            wlast_seen     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Channel_Granted && pick_any) begin
                        Grant_OneHot   <= pick_onehot;
                        Selected_Slave <= pick_index;
                        state          <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    // W may complete before AW; remember it so DATA is skipped.
                    if (W_LAST_HS) begin
                        wlast_seen <= 1'b1;
                    end
                    if (AW_HS) begin
                        state <= (wlast_seen || W_LAST_HS) ? ST_RESP : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (W_LAST_HS) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (B_HS) begin
                        state          <= ST_IDLE;
                        Grant_OneHot   <= '0;
                        Selected_Slave <= '0;
                        wlast_seen     <= 1'b0;
                        rr_ptr         <= Selected_Slave;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign Busy            = (state != ST_IDLE);
    assign Channel_Request = Busy;

endmodule

// File: tb/tb_axi_write_arbiter_rr.sv
// Randomised scoreboard bench: a round-robin and a fixed-priority instance
// share stimulus; expected grants come from a search over the request vector.
module tb_axi_write_arbiter_rr;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic [N-1:0]  M_AWVALID;
    logic          Channel_Granted, AW_HS, W_LAST_HS, B_HS;
    logic          cr_rr, busy_rr, cr_fx, busy_fx;
    logic [N-1:0]  oh_rr, oh_fx;
    logic [IW-1:0] sel_rr, sel_fx;

    int checks   = 0;
    int failures = 0;
    int exp_rr_q[$];
    int exp_fx_q[$];
    int rr_ptr_m;
    int cur_rr, cur_fx;
    int mon_rr, mon_fx;
    logic prev_busy = 1'b0;

    always #5 ACLK = ~ACLK;

    axi_write_arbiter_rr #(.NUM_MASTERS(N), .RR_MODE(1)) u_rr (
        .ACLK(ACLK), .ARESET(ARESET), .M_AWVALID(M_AWVALID),
        .Channel_Granted(Channel_Granted), .AW_HS(AW_HS), .W_LAST_HS(W_LAST_HS),
        .B_HS(B_HS), .Channel_Request(cr_rr), .Grant_OneHot(oh_rr),
        .Selected_Slave(sel_rr), .Busy(busy_rr)
    );

    axi_write_arbiter_rr #(.NUM_MASTERS(N), .RR_MODE(0)) u_fx (
        .ACLK(ACLK), .ARESET(ARESET), .M_AWVALID(M_AWVALID),
        .Channel_Granted(Channel_Granted), .AW_HS(AW_HS), .W_LAST_HS(W_LAST_HS),
        .B_HS(B_HS), .Channel_Request(cr_fx), .Grant_OneHot(oh_fx),
        .Selected_Slave(sel_fx), .Busy(busy_fx)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arbitration: first requester after ptr (round-robin) or lowest index (fixed).
    function automatic int pick(input logic [N-1:0] req, input int ptr, input bit rr);
        int idx;
        for (int off = 1; off <= N; off++) begin
            idx = rr ? (ptr + off) % N : off - 1;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic bit inv_ok(input logic [N-1:0] oh, input logic [IW-1:0] sel,
                                  input logic busy, input logic cr);
        if ($countones(oh) > 1 || cr !== busy) return 1'b0;
        if (busy) return (oh[sel] === 1'b1);
        return (oh == '0 && sel == '0);
    endfunction

    function automatic logic [N-1:0] rnd_req();
        logic [N-1:0] r;
        do r = N'($urandom); while (r == '0);
        return r;
    endfunction

    task automatic tick();
        @(posedge ACLK);
        @(negedge ACLK);
    endtask

    task automatic start_txn(input logic [N-1:0] req);
        M_AWVALID       = req;
        Channel_Granted = 1'b1;
        cur_rr = pick(req, rr_ptr_m, 1'b1);
        cur_fx = pick(req, 0, 1'b0);
        exp_rr_q.push_back(cur_rr);
        exp_fx_q.push_back(cur_fx);
        tick();
        check("grant_latency", busy_rr, 1);
        // Requests and channel availability may now wander; the grant must not move.
        M_AWVALID       = N'($urandom);
        Channel_Granted = 1'($urandom);
    endtask

    task automatic held();
        check("grant_held_rr", oh_rr, 1 << cur_rr);
        check("grant_held_fx", oh_fx, 1 << cur_fx);
    endtask

    // kind 0: AW then W with stray B/AW; kind 1: W two cycles before AW; kind 2: AW and W together.
    task automatic finish_txn(input int kind, input logic [N-1:0] next_req);
        case (kind)
            0: begin
                B_HS = 1'b1; tick(); B_HS = 1'b0;
                check("b_in_addr_ignored", busy_rr, 1);
                AW_HS = 1'b1; tick(); AW_HS = 1'b0;
                held();
                B_HS = 1'b1; tick(); B_HS = 1'b0;
                check("b_in_data_ignored", busy_rr, 1);
                AW_HS = 1'b1; tick(); AW_HS = 1'b0;
                W_LAST_HS = 1'b1; tick(); W_LAST_HS = 1'b0;
                held();
            end
            1: begin
                W_LAST_HS = 1'b1; tick(); W_LAST_HS = 1'b0;
                tick();
                AW_HS = 1'b1; tick(); AW_HS = 1'b0;
                held();
            end
            default: begin
                AW_HS = 1'b1; W_LAST_HS = 1'b1; tick();
                AW_HS = 1'b0; W_LAST_HS = 1'b0;
                held();
            end
        endcase
        M_AWVALID       = next_req;
        Channel_Granted = 1'b1;
        B_HS = 1'b1; tick(); B_HS = 1'b0;
        check("idle_gap", busy_rr, 0);
        check("idle_grant_clear", oh_rr, 0);
        rr_ptr_m = cur_rr;
    endtask

    // Scoreboard monitor: pops an expected grant on every rising Busy.
    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (busy_rr && !prev_busy) begin
                if (exp_rr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_grant: got %0h expected none at %0t", oh_rr, $time);
                end else begin
                    mon_rr = exp_rr_q.pop_front();
                    mon_fx = exp_fx_q.pop_front();
                    check("grant_rr", oh_rr, 1 << mon_rr);
                    check("sel_rr", sel_rr, mon_rr);
                    check("grant_fx", oh_fx, 1 << mon_fx);
                    check("sel_fx", sel_fx, mon_fx);
                end
            end
            check("busy_match", busy_fx, busy_rr);
            check("invariants_rr", inv_ok(oh_rr, sel_rr, busy_rr, cr_rr), 1);
            check("invariants_fx", inv_ok(oh_fx, sel_fx, busy_fx, cr_fx), 1);
        end
        prev_busy <= busy_rr;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] nxt;
        ARESET = 1'b1;
        M_AWVALID = '0; Channel_Granted = 1'b0;
        AW_HS = 1'b0; W_LAST_HS = 1'b0; B_HS = 1'b0;
        rr_ptr_m = N - 1;
        tick(); tick();
        check("reset_grant", oh_rr, 0);
        check("reset_sel", sel_rr, 0);
        check("reset_busy", busy_rr, 0);
        check("reset_chreq", cr_rr, 0);
        ARESET = 1'b0;
        tick();

        // Reset asserted in DATA while master 2 holds the grant.
        start_txn(4'b0100);
        AW_HS = 1'b1; tick(); AW_HS = 1'b0;
        held();
        #2 ARESET = 1'b1;
        #1;
        check("async_reset_grant_rr", oh_rr, 0);
        check("async_reset_grant_fx", oh_fx, 0);
        check("async_reset_sel", sel_rr, 0);
        check("async_reset_busy", busy_rr, 0);
        check("async_reset_chreq", cr_rr, 0);
        M_AWVALID = '0; Channel_Granted = 1'b0;
        tick();
        ARESET = 1'b0;
        rr_ptr_m = N - 1;
        tick();

        // Round-robin fairness, back to back: 0,1,2,3,0 (fixed instance: 0 always).
        start_txn(4'b1111);
        for (int i = 0; i < 5; i++) begin
            finish_txn(i % 3, (i < 4) ? 4'b1111 : 4'b0000);
            if (i < 4) start_txn(4'b1111);
        end

        // 1010 repeated: fixed always picks 1; round-robin alternates.
        for (int i = 0; i < 3; i++) begin
            start_txn(4'b1010);
            finish_txn(2, 4'b0000);
        end

        // Pointer at 2 with requests 0011 wraps past 3 to grant 0.
        start_txn(4'b0100);
        finish_txn(1, 4'b0000);
        start_txn(4'b0011);
        finish_txn(0, 4'b0000);

        // Channel not granted: no arbitration; W_LAST_HS in IDLE must not be latched.
        M_AWVALID = 4'b0100; Channel_Granted = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("gated_no_grant", busy_rr, 0);
        end
        W_LAST_HS = 1'b1; tick(); W_LAST_HS = 1'b0;
        check("wlast_idle_no_grant", busy_rr, 0);
        start_txn(4'b0100);
        M_AWVALID = '0; Channel_Granted = 1'b0;
        finish_txn(0, 4'b0000);

        // Randomised transactions with mixed handshake orders and idle gaps.
        nxt = rnd_req();
        start_txn(nxt);
        for (int i = 0; i < 40; i++) begin
            nxt = (i == 39 || $urandom_range(1, 0) == 0) ? 4'b0000 : rnd_req();
            finish_txn(int'($urandom_range(2, 0)), nxt);
            if (i == 39) break;
            if (nxt == '0) begin
                repeat ($urandom_range(3, 1)) begin
                    M_AWVALID = N'($urandom); Channel_Granted = 1'b0;
                    tick();
                    check("random_gated_idle", busy_rr, 0);
                end
                nxt = rnd_req();
            end
            start_txn(nxt);
        end

        M_AWVALID = '0; Channel_Granted = 1'b0;
        tick(); tick();
        check("queue_drained", exp_rr_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
